// File: rtl/tt_um_counter_checker.sv
// Receive-side checker for a 4-bit free-running counter stream: tracks lock,
// flags sequence errors and keeps a saturating error count.
module tt_um_counter_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] ui_in,
  input  logic [3:0] uio_in,
  output logic [3:0] uo_out,
  output logic [3:0] uio_out,
  output logic [3:0] uio_oe
);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [3:0] LOCK_N = LOCK_COUNT[3:0];
  localparam logic [3:0] LOSS_N = LOSS_COUNT[3:0];

  logic [1:0] state;
  logic [3:0] prev;
  logic [3:0] good_cnt;
  logic [3:0] bad_cnt;
  logic [3:0] err_cnt;
  logic       err_pulse;
  logic       wrap_pulse;

  logic       clr_err;
  logic       valid;
  logic [3:0] prev_inc;
  logic [3:0] good_inc;
  logic [3:0] bad_inc;
  logic       match;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  assign clr_err  = uio_in[0];
  assign valid    = uio_in[1];
  assign prev_inc = prev + 4'd1;
  assign good_inc = good_cnt + 4'd1;
  assign bad_inc  = bad_cnt + 4'd1;
  assign match    = (ui_in == prev_inc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_HUNT;
      prev       <= 4'd0;
      good_cnt   <= 4'd0;
      bad_cnt    <= 4'd0;
      err_cnt    <= 4'd0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
      if (valid) begin
        // every accepted sample becomes the new reference, so a mismatch resyncs
        prev <= ui_in;
        case (state)
          ST_HUNT: begin
            state    <= ST_SYNC;
            good_cnt <= 4'd0;
          end
          ST_SYNC: begin
            if (match) begin
              if (good_inc == LOCK_N) begin
                state    <= ST_LOCKED;
                good_cnt <= 4'd0;
                bad_cnt  <= 4'd0;
              end else begin
                good_cnt <= good_inc;
              end
            end else begin
              good_cnt <= 4'd0;
            end
          end
          ST_LOCKED: begin
            if (match) begin
              bad_cnt    <= 4'd0;
              wrap_pulse <= (ui_in == 4'd0);
            end else begin
              err_pulse <= 1'b1;
              err_cnt   <= sat_inc(err_cnt);
              if (bad_inc == LOSS_N) begin
                state    <= ST_SYNC;
                good_cnt <= 4'd0;
                bad_cnt  <= 4'd0;
              end else begin
                bad_cnt <= bad_inc;
              end
            end
          end
          default: state <= ST_HUNT;
        endcase
      end
      // clear wins over an error counted on the same edge
      if (clr_err) err_cnt <= 4'd0;
    end
  end

  assign uo_out  = err_cnt;
  assign uio_out = {(err_cnt == 4'hF), wrap_pulse, err_pulse, (state == ST_LOCKED)};
  assign uio_oe  = 4'b1111;

  logic _unused;
  assign _unused = &{1'b0, rst_n, ena, uio_in[3:2]};

endmodule
